// File: rtl/revo_phase_encoder_pkg.sv
// rtl/revo_phase_encoder_pkg.sv - shared constants, phase encodings and phase picker for the revo path
package revo_pkg;

  localparam int WORD_W = 4;
  localparam logic [7:0] WORD_NULL = 8'b1100_0000;
  localparam logic [7:0] WORD_TRG  = 8'b0011_1111;

  typedef enum logic [1:0] {
    PH_0   = 2'd0,
    PH_90  = 2'd1,
    PH_180 = 2'd2,
    PH_270 = 2'd3
  } phase_e;

  typedef struct packed {
    logic   hit;
    phase_e ph;
  } phase_pick_t;

  // Only a clean single edge names a phase; empty or multi-edge words report no hit.
  function automatic phase_pick_t pick_phase(input logic [WORD_W-1:0] pulse);
    phase_pick_t r;
    r.hit = 1'b1;
    r.ph  = PH_0;
    case (pulse)
      4'b1000: r.ph = PH_0;
      4'b0100: r.ph = PH_90;
      4'b0010: r.ph = PH_180;
      4'b0001: r.ph = PH_270;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/revo_phase_encoder_if.sv
// rtl/revo_phase_encoder_if.sv - revo input and word-rate output bundle
interface revo_phase_encoder_if;
  import revo_pkg::*;

  logic              revo_in;
  logic              word_valid;
  logic [WORD_W-1:0] revo_word;
  logic [WORD_W-1:0] pulse_word;
  logic [1:0]        select;
  logic              trg;
  logic [7:0]        enc_word;

  modport master (
    input  revo_in,
    output word_valid, revo_word, pulse_word, select, trg, enc_word
  );

  modport slave (
    output revo_in,
    input  word_valid, revo_word, pulse_word, select, trg, enc_word
  );

endinterface

// File: rtl/revo_phase_encoder_deserializer.sv
// rtl/revo_phase_encoder_deserializer.sv - revo synchronizer, 4:1 deserializer and rising-edge detect
module revo_deserializer
  import revo_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              revo_in_i,
  output logic              word_upd_o,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] revo_word_o,
  output logic [WORD_W-1:0] pulse_word_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  // Only the three older samples are ever read back, so the fourth shift bit is not kept.
  logic [WORD_W-2:0]      sh_q;
  logic [1:0]             cnt_q;
  logic                   word_valid_q;
  logic [WORD_W-1:0]      revo_word_q;
  logic [WORD_W-1:0]      revo_word_d;
  logic                   prev_lsb_q;
  logic                   s;

  assign s           = sync_q[SYNC_STAGES-1];
  assign word_upd_o  = (cnt_q == 2'd3);
  assign revo_word_d = {sh_q, s};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '0;
      sh_q         <= '0;
      cnt_q        <= '0;
      word_valid_q <= 1'b0;
      revo_word_q  <= '0;
      prev_lsb_q   <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], revo_in_i};
      sh_q         <= {sh_q[WORD_W-3:0], s};
      cnt_q        <= cnt_q + 2'd1;
      word_valid_q <= word_upd_o;
      if (word_upd_o) begin
        revo_word_q <= revo_word_d;
        prev_lsb_q  <= revo_word_q[0];
      end
    end
  end

  // Each sample is compared with the one before it; bit 3 looks back into the previous word.
  assign pulse_word_o = revo_word_q & ~{prev_lsb_q, revo_word_q[WORD_W-1:1]};
  assign word_valid_o = word_valid_q;
  assign revo_word_o  = revo_word_q;

endmodule

// File: rtl/revo_phase_encoder.sv
// rtl/revo_phase_encoder.sv - revo phase select, trigger pipeline and line-word encoder
module revo_phase_encoder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] WORD_NULL   = revo_pkg::WORD_NULL,
  parameter logic [7:0] WORD_TRG    = revo_pkg::WORD_TRG
) (
  input  logic                 clock,
  input  logic                 reset_n,
  revo_phase_encoder_if.master bus
);
  import revo_pkg::*;

  logic              word_upd;
  logic              word_valid;
  logic [WORD_W-1:0] revo_word;
  logic [WORD_W-1:0] pulse_word;

  phase_pick_t       pick;
  phase_e            select_q;
  phase_e            select_d;
  logic [WORD_W-1:0] d_q;
  logic              trg_q;
  logic [7:0]        enc_q;

  revo_deserializer #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deser (
    .clock        (clock),
    .reset_n      (reset_n),
    .revo_in_i    (bus.revo_in),
    .word_upd_o   (word_upd),
    .word_valid_o (word_valid),
    .revo_word_o  (revo_word),
    .pulse_word_o (pulse_word)
  );

  always_comb begin
    pick     = pick_phase(pulse_word);
    select_d = pick.hit ? pick.ph : select_q;
  end

  // Word-rate pipeline: revo_word -> d -> trg -> enc_word, one stage per word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      select_q <= PH_0;
      d_q      <= '0;
      trg_q    <= 1'b0;
      enc_q    <= WORD_NULL;
    end else if (word_upd) begin
      select_q <= select_d;
      d_q      <= revo_word;
      trg_q    <= |d_q;
      enc_q    <= trg_q ? WORD_TRG : WORD_NULL;
    end
  end

  assign bus.word_valid = word_valid;
  assign bus.revo_word  = revo_word;
  assign bus.pulse_word = pulse_word;
  assign bus.select     = select_q;
  assign bus.trg        = trg_q;
  assign bus.enc_word   = enc_q;

endmodule

// File: tb/tb_revo_phase_encoder.sv
// tb/tb_revo_phase_encoder.sv - scoreboard bench for revo_phase_encoder
module tb_revo_phase_encoder;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  revo_phase_encoder_if bus ();

  revo_phase_encoder #(
    .SYNC_STAGES (2),
    .WORD_NULL   (8'b1100_0000),
    .WORD_TRG    (8'b0011_1111)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] rw;
    logic [3:0] pw;
    logic [1:0] sel;
    logic       trg;
    logic [7:0] enc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   gap    = 0;
  int   widx   = 0;
  bit   mon_en = 1'b0;

  // Word k carries the four revo_in samples driven on edges 4k-5 .. 4k-2 after release.
  logic [3:0] nib_tab [35] = '{
    4'h0,4'h0,4'h0,4'h4,4'h0,4'h0,4'h0,4'h1,4'hE,4'h0,
    4'h0,4'h0,4'h8,4'h0,4'h4,4'h0,4'h2,4'h0,4'h1,4'h0,
    4'hA,4'h0,4'h0,4'h7,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,
    4'hE,4'h0,4'h0,4'h0,4'h0};
  logic [3:0] pw_tab [35] = '{
    4'h0,4'h0,4'h0,4'h4,4'h0,4'h0,4'h0,4'h1,4'h0,4'h0,
    4'h0,4'h0,4'h8,4'h0,4'h4,4'h0,4'h2,4'h0,4'h1,4'h0,
    4'hA,4'h0,4'h0,4'h4,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,
    4'h0,4'h0,4'h0,4'h0,4'h0};
  logic [1:0] sel_tab [35] = '{
    2'd0,2'd0,2'd0,2'd0,2'd1,2'd1,2'd1,2'd1,2'd3,2'd3,
    2'd3,2'd3,2'd3,2'd0,2'd0,2'd1,2'd1,2'd2,2'd2,2'd3,
    2'd3,2'd3,2'd3,2'd3,2'd1,2'd1,2'd1,2'd1,2'd1,2'd1,
    2'd1,2'd1,2'd1,2'd1,2'd1};
  logic       trg_tab [35] = '{
    0,0,0,0,0,1,0,0,0,1,
    1,0,0,0,1,0,1,0,1,0,
    1,0,1,0,0,1,1,1,1,1,
    1,1,1,0,0};
  logic       enc_tab [35] = '{
    0,0,0,0,0,0,1,0,0,0,
    1,1,0,0,0,1,0,1,0,1,
    0,1,0,1,0,0,1,1,1,1,
    1,1,1,1,0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int w);
    exp_t e;
    e.rw  = nib_tab[w];
    e.pw  = pw_tab[w];
    e.sel = sel_tab[w];
    e.trg = trg_tab[w];
    e.enc = enc_tab[w] ? 8'h3F : 8'hC0;
    return e;
  endfunction

  task automatic drive(input logic b);
    bus.revo_in = b;
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      gap = 0;
    end else if (mon_en) begin
      gap++;
      if (bus.word_valid) begin
        widx++;
        chk($sformatf("word%0d_spacing", widx), gap, 4);
        gap = 0;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word%0d_unexpected: got word_valid with no expected entry", widx);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk($sformatf("word%0d_revo_word", widx), bus.revo_word, e.rw);
          chk($sformatf("word%0d_pulse_word", widx), bus.pulse_word, e.pw);
          chk($sformatf("word%0d_select", widx), bus.select, e.sel);
          chk($sformatf("word%0d_trg", widx), bus.trg, e.trg);
          chk($sformatf("word%0d_enc_word", widx), bus.enc_word, e.enc);
        end
      end
    end
  end

  initial begin
    int t;
    bus.revo_in = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("rst_word_valid", bus.word_valid, 0);
    chk("rst_revo_word", bus.revo_word, 0);
    chk("rst_pulse_word", bus.pulse_word, 0);
    chk("rst_select", bus.select, 0);
    chk("rst_trg", bus.trg, 0);
    chk("rst_enc_word", bus.enc_word, 8'hC0);

    sb_q.push_back(mk(0));
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    drive(1'b0);
    drive(1'b0);
    for (int w = 1; w < 35; w++) begin
      sb_q.push_back(mk(w));
      for (int b = 3; b >= 0; b--) drive(nib_tab[w][b]);
    end
    bus.revo_in = 1'b0;

    t = 0;
    while (sb_q.size() != 0 && t < 40) begin
      @(posedge clock);
      t++;
    end
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("words_seen", widx, 35);
    mon_en = 1'b0;

    repeat (8) drive(1'b1);
    bus.revo_in = 1'b0;
    t = 0;
    while (!bus.trg && t < 40) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("trg_before_async_reset", bus.trg, 1);

    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_trg", bus.trg, 0);
    chk("arst_select", bus.select, 0);
    chk("arst_revo_word", bus.revo_word, 0);
    chk("arst_pulse_word", bus.pulse_word, 0);
    chk("arst_word_valid", bus.word_valid, 0);
    chk("arst_enc_word", bus.enc_word, 8'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
